// File: rtl/bram_acc_pkg.sv
// Shared state encoding and mode constants for the BRAM accumulator engine.
package bram_acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_RSUM = 2'd0;
  localparam logic [1:0] MODE_FSUM = 2'd1;
  localparam logic [1:0] MODE_RMAX = 2'd2;

endpackage

// File: rtl/acc_lane.sv
// One accumulator lane: running sum (wrap or saturate) or running max, with clear.
module acc_lane #(
  parameter int unsigned IN_DW  = 8,
  parameter int unsigned ACC_DW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic              is_max_i,
  input  logic              sat_i,
  input  logic [IN_DW-1:0]  din_i,
  output logic [ACC_DW-1:0] upd_o
);

  logic [ACC_DW-1:0] acc_q;
  logic [ACC_DW-1:0] din_ext;
  logic [ACC_DW:0]   sum;

  assign din_ext = ACC_DW'(din_i);
  assign sum     = {1'b0, acc_q} + {1'b0, din_ext};

  // upd_o is the value acc_q takes on an enabled cycle; the top also captures it for bram1.
  always_comb begin
    upd_o = sum[ACC_DW-1:0];
    if (is_max_i) begin
      upd_o = (din_ext > acc_q) ? din_ext : acc_q;
    end else if (sat_i && sum[ACC_DW]) begin
      upd_o = '1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= upd_o;
    end
  end

endmodule

// File: rtl/bram_acc_engine.sv
// Streams N rows from bram0, reduces each lane (sum/max), writes results to bram1.
module bram_acc_engine
  import bram_acc_pkg::*;
#(
  parameter int unsigned NUM_LANE = 4,
  parameter int unsigned IN_DW    = 8,
  parameter int unsigned ACC_DW   = 16,
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned CNT_BIT  = 31
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_run_i,
  input  logic [CNT_BIT-1:0]         run_count_i,
  input  logic [1:0]                 mode_i,
  input  logic                       sat_i,
  input  logic [AWIDTH-1:0]          src_base_i,
  input  logic [AWIDTH-1:0]          dst_base_i,
  input  logic [NUM_LANE*IN_DW-1:0]  q_b0_i,
  input  logic [NUM_LANE*ACC_DW-1:0] q_b1_i,
  output logic                       idle_o,
  output logic                       read_o,
  output logic                       write_o,
  output logic                       done_o,
  output logic [AWIDTH-1:0]          addr_b0_o,
  output logic                       ce_b0_o,
  output logic                       we_b0_o,
  output logic [NUM_LANE*IN_DW-1:0]  d_b0_o,
  output logic [AWIDTH-1:0]          addr_b1_o,
  output logic                       ce_b1_o,
  output logic                       we_b1_o,
  output logic [NUM_LANE*ACC_DW-1:0] d_b1_o
);

  state_e                     state_q, state_d;
  logic [CNT_BIT-1:0]         n_q, row_q;
  logic [1:0]                 mode_q;
  logic                       sat_q;
  logic [AWIDTH-1:0]          src_q, dst_q;
  logic                       drain_q;
  logic                       v1_q, l1_q;
  logic [AWIDTH-1:0]          idx1_q;
  logic                       wr_q;
  logic [AWIDTH-1:0]          waddr_q;
  logic [NUM_LANE*ACC_DW-1:0] wdata_q;
  logic [NUM_LANE*ACC_DW-1:0] upd_all;

  logic start_acc, last_row, is_final, is_max, wr_next;
  logic unused_q_b1;

  assign unused_q_b1 = ^q_b1_i;
  assign start_acc   = (state_q == StIdle) && start_run_i;
  assign last_row    = (row_q == n_q - CNT_BIT'(1));
  assign is_final    = (mode_q == MODE_FSUM);
  assign is_max      = (mode_q == MODE_RMAX);
  // v1_q marks the cycle bram0 data is valid; the write lands one cycle later.
  assign wr_next     = v1_q && (!is_final || l1_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_run_i) state_d = (run_count_i == '0) ? StDone : StRun;
      StRun:   if (last_row) state_d = StDrain;
      StDrain: if (drain_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      row_q   <= '0;
      mode_q  <= '0;
      sat_q   <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      drain_q <= 1'b0;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      idx1_q  <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        n_q    <= run_count_i;
        mode_q <= mode_i;
        sat_q  <= sat_i;
        src_q  <= src_base_i;
        dst_q  <= dst_base_i;
        row_q  <= '0;
      end else if (state_q == StRun) begin
        row_q <= row_q + CNT_BIT'(1);
      end
      drain_q <= (state_q == StDrain) && !drain_q;
      v1_q    <= (state_q == StRun);
      l1_q    <= (state_q == StRun) && last_row;
      idx1_q  <= AWIDTH'(row_q);
      wr_q    <= wr_next;
      if (wr_next) begin
        waddr_q <= is_final ? dst_q : dst_q + idx1_q;
        wdata_q <= upd_all;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    acc_lane #(
      .IN_DW  (IN_DW),
      .ACC_DW (ACC_DW)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (start_acc),
      .en_i     (v1_q),
      .is_max_i (is_max),
      .sat_i    (sat_q),
      .din_i    (q_b0_i[g*IN_DW +: IN_DW]),
      .upd_o    (upd_all[g*ACC_DW +: ACC_DW])
    );
  end

  assign idle_o    = (state_q == StIdle);
  assign read_o    = (state_q == StRun);
  assign done_o    = (state_q == StDone);
  assign ce_b0_o   = read_o;
  assign addr_b0_o = src_q + AWIDTH'(row_q);
  assign we_b0_o   = 1'b0;
  assign d_b0_o    = '0;
  assign ce_b1_o   = wr_q;
  assign we_b1_o   = wr_q;
  assign write_o   = wr_q;
  assign addr_b1_o = waddr_q;
  assign d_b1_o    = wdata_q;

endmodule

// File: tb/tb_bram_acc_engine.sv
// Self-checking bench: bram0 model, write scoreboard, one task per scenario.
module tb_bram_acc_engine;

  localparam int unsigned CB = 31;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_run_i = 1'b0;
  logic [CB-1:0] run_count_i = '0;
  logic [1:0]    mode_i = '0;
  logic          sat_i = 1'b0;
  logic [7:0]    src_base_i = '0;
  logic [7:0]    dst_base_i = '0;
  logic [31:0]   q_b0_i = '0;

  logic        idle_o, read_o, write_o, done_o, ce_b0_o, we_b0_o, ce_b1_o, we_b1_o;
  logic [7:0]  addr_b0_o, addr_b1_o;
  logic [31:0] d_b0_o;
  logic [63:0] d_b1_o;

  logic        b_idle, b_read, b_write, b_done, b_ce0, b_we0, b_ce1, b_we1;
  logic [7:0]  b_addr0, b_addr1;
  logic [31:0] b_d0;
  logic [35:0] b_d1;

  bram_acc_engine u_dut (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .mode_i(mode_i), .sat_i(sat_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .q_b0_i(q_b0_i), .q_b1_i(64'h0), .idle_o(idle_o), .read_o(read_o), .write_o(write_o),
    .done_o(done_o), .addr_b0_o(addr_b0_o), .ce_b0_o(ce_b0_o), .we_b0_o(we_b0_o),
    .d_b0_o(d_b0_o), .addr_b1_o(addr_b1_o), .ce_b1_o(ce_b1_o), .we_b1_o(we_b1_o),
    .d_b1_o(d_b1_o)
  );

  bram_acc_engine #(.ACC_DW(9)) u_dut9 (
    .clk(clk), .reset_n(reset_n), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .mode_i(mode_i), .sat_i(sat_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .q_b0_i(q_b0_i), .q_b1_i(36'h0), .idle_o(b_idle), .read_o(b_read), .write_o(b_write),
    .done_o(b_done), .addr_b0_o(b_addr0), .ce_b0_o(b_ce0), .we_b0_o(b_we0),
    .d_b0_o(b_d0), .addr_b1_o(b_addr1), .ce_b1_o(b_ce1), .we_b1_o(b_we1),
    .d_b1_o(b_d1)
  );

  always #5 clk = ~clk;

  logic [31:0] mem0 [256];
  always @(posedge clk) if (ce_b0_o) q_b0_i <= mem0[addr_b0_o];

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [63:0] data;
    logic [35:0] data9;
  } wr_t;

  wr_t        obs_wr[$];
  wr_t        exp_wr[$];
  int         rd_cyc[$];
  logic [7:0] rd_addr[$];
  int         done_cyc[$];
  bit         timeout;
  int         checks = 0;
  int         failures = 0;

  function automatic wr_t mk(int cyc, logic [7:0] addr, logic [63:0] data, logic [35:0] d9);
    wr_t w;
    w.cyc = cyc; w.addr = addr; w.data = data; w.data9 = d9;
    return w;
  endfunction

  function automatic logic [35:0] rep9(logic [8:0] v);
    return {v, v, v, v};
  endfunction

  // Runs one job and records every read, write and done pulse by cycle after the start edge.
  task automatic do_run(input int n, input logic [1:0] mode, input logic sat,
                        input logic [7:0] src, input logic [7:0] dst, input bit hold);
    wr_t w;
    bit  seen_done;
    obs_wr.delete(); rd_cyc.delete(); rd_addr.delete(); done_cyc.delete();
    timeout = 0; seen_done = 0;
    @(negedge clk);
    run_count_i = CB'(n); mode_i = mode; sat_i = sat;
    src_base_i = src; dst_base_i = dst; start_run_i = 1'b1;
    @(posedge clk); #1;
    start_run_i = hold;
    for (int c = 1; c <= n + 20; c++) begin
      if (hold && c >= n + 3) start_run_i = 1'b0;
      if (ce_b0_o) begin rd_cyc.push_back(c); rd_addr.push_back(addr_b0_o); end
      if (ce_b1_o) begin
        w = mk(c, addr_b1_o, d_b1_o, b_d1);
        obs_wr.push_back(w);
      end
      if (done_o) begin done_cyc.push_back(c); seen_done = 1; end
      if (seen_done && idle_o) return;
      @(posedge clk); #1;
    end
    timeout = 1;
    start_run_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({idle_o, read_o, write_o, done_o, ce_b0_o, we_b0_o, ce_b1_o, we_b1_o} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 10000000",
               {idle_o, read_o, write_o, done_o, ce_b0_o, we_b0_o, ce_b1_o, we_b1_o});
    end
    checks++;
    if ({addr_b0_o, addr_b1_o, d_b1_o, d_b0_o} !== '0) begin
      failures++;
      $display("FAIL reset_buses: got a0=%h a1=%h d1=%h d0=%h expected all zero",
               addr_b0_o, addr_b1_o, d_b1_o, d_b0_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_running_sum;
    wr_t o, e;
    mem0[8'h10] = 32'h04030201; mem0[8'h11] = 32'h01010101; mem0[8'h12] = 32'h10FF0000;
    exp_wr.push_back(mk(3, 8'h20, 64'h0004_0003_0002_0001, '0));
    exp_wr.push_back(mk(4, 8'h21, 64'h0005_0004_0003_0002, '0));
    exp_wr.push_back(mk(5, 8'h22, 64'h0015_0103_0003_0002, '0));
    do_run(3, 2'd0, 1'b0, 8'h10, 8'h20, 1'b0);
    checks++;
    if (timeout) begin failures++; $display("FAIL rsum_timeout: got no idle expected idle"); end
    foreach (obs_wr[i]) begin
      o = obs_wr[i];
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL rsum_extra_write: got write cyc=%0d addr=%h expected none", o.cyc, o.addr);
      end else begin
        e = exp_wr.pop_front();
        if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
          failures++;
          $display("FAIL rsum_write: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                   o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    checks++;
    if (exp_wr.size() != 0) begin
      failures++;
      $display("FAIL rsum_missing: got %0d writes short expected 0", exp_wr.size());
      exp_wr.delete();
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 6) begin
      failures++;
      $display("FAIL rsum_done: got %0d pulses first=%0d expected 1 pulse at 6",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (rd_cyc.size() != 3 || rd_addr[0] !== 8'h10 || rd_addr[2] !== 8'h12) begin
      failures++;
      $display("FAIL rsum_reads: got %0d reads expected 3 at 10..12", rd_cyc.size());
    end
  endtask

  task automatic test_final_sum;
    wr_t o, e;
    exp_wr.push_back(mk(5, 8'h20, 64'h0015_0103_0003_0002, '0));
    do_run(3, 2'd1, 1'b0, 8'h10, 8'h20, 1'b0);
    checks++;
    if (timeout) begin failures++; $display("FAIL fsum_timeout: got no idle expected idle"); end
    checks++;
    if (obs_wr.size() != 1) begin
      failures++;
      $display("FAIL fsum_count: got %0d writes expected 1", obs_wr.size());
    end
    foreach (obs_wr[i]) begin
      o = obs_wr[i];
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        checks++;
        if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
          failures++;
          $display("FAIL fsum_write: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                   o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    exp_wr.delete();
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 6) begin
      failures++;
      $display("FAIL fsum_done: got %0d pulses expected 1 at 6", done_cyc.size());
    end
  endtask

  task automatic test_running_max;
    wr_t o, e;
    mem0[8'h30] = 32'h05010903; mem0[8'h31] = 32'h02080104;
    exp_wr.push_back(mk(3, 8'h40, 64'h0005_0001_0009_0003, '0));
    exp_wr.push_back(mk(4, 8'h41, 64'h0005_0008_0009_0004, '0));
    do_run(2, 2'd2, 1'b1, 8'h30, 8'h40, 1'b0);
    checks++;
    if (obs_wr.size() != 2 || timeout) begin
      failures++;
      $display("FAIL rmax_count: got %0d writes timeout=%0d expected 2 writes", obs_wr.size(), timeout);
    end
    foreach (obs_wr[i]) begin
      o = obs_wr[i];
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        checks++;
        if (o.cyc !== e.cyc || o.addr !== e.addr || o.data !== e.data) begin
          failures++;
          $display("FAIL rmax_write: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                   o.cyc, o.addr, o.data, e.cyc, e.addr, e.data);
        end
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_saturation;
    wr_t o, e;
    for (int i = 0; i < 3; i++) mem0[8'h50 + i] = 32'hFFFF_FFFF;
    for (int s = 0; s < 2; s++) begin
      exp_wr.push_back(mk(3, 8'h60, '0, rep9(9'h0FF)));
      exp_wr.push_back(mk(4, 8'h61, '0, rep9(9'h1FE)));
      exp_wr.push_back(mk(5, 8'h62, '0, rep9((s == 1) ? 9'h1FF : 9'h0FD)));
      do_run(3, 2'd0, s[0], 8'h50, 8'h60, 1'b0);
      checks++;
      if (obs_wr.size() != 3 || timeout) begin
        failures++;
        $display("FAIL sat%0d_count: got %0d writes expected 3", s, obs_wr.size());
      end
      foreach (obs_wr[i]) begin
        o = obs_wr[i];
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          checks++;
          if (o.cyc !== e.cyc || o.addr !== e.addr || o.data9 !== e.data9) begin
            failures++;
            $display("FAIL sat%0d_write: got cyc=%0d addr=%h data=%h expected cyc=%0d addr=%h data=%h",
                     s, o.cyc, o.addr, o.data9, e.cyc, e.addr, e.data9);
          end
        end
      end
      exp_wr.delete();
    end
  endtask

  task automatic test_zero_rows;
    do_run(0, 2'd0, 1'b0, 8'h10, 8'h20, 1'b0);
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 1 || timeout) begin
      failures++;
      $display("FAIL n0_done: got %0d pulses first=%0d expected 1 pulse at 1",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (rd_cyc.size() != 0 || obs_wr.size() != 0) begin
      failures++;
      $display("FAIL n0_access: got %0d reads %0d writes expected 0 0", rd_cyc.size(), obs_wr.size());
    end
  endtask

  task automatic test_addr_wrap;
    logic [7:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    do_run(4, 2'd0, 1'b0, 8'hFE, 8'hFF, 1'b0);
    checks++;
    if (rd_addr.size() != 4 || timeout) begin
      failures++;
      $display("FAIL wrap_count: got %0d reads expected 4", rd_addr.size());
    end
    for (int i = 0; i < 4 && i < rd_addr.size(); i++) begin
      checks++;
      if (rd_addr[i] !== exp_a[i] || rd_cyc[i] != i + 1) begin
        failures++;
        $display("FAIL wrap_addr%0d: got %h@%0d expected %h@%0d", i, rd_addr[i], rd_cyc[i],
                 exp_a[i], i + 1);
      end
    end
    checks++;
    if (obs_wr.size() != 4 || obs_wr[1].addr !== 8'h00) begin
      failures++;
      $display("FAIL wrap_dst: got %0d writes expected 4 with second at 00", obs_wr.size());
    end
  endtask

  task automatic test_start_held;
    do_run(3, 2'd0, 1'b0, 8'h10, 8'h20, 1'b1);
    checks++;
    if (rd_cyc.size() != 3 || obs_wr.size() != 3 || done_cyc.size() != 1 || timeout) begin
      failures++;
      $display("FAIL hold_counts: got reads=%0d writes=%0d dones=%0d expected 3 3 1",
               rd_cyc.size(), obs_wr.size(), done_cyc.size());
    end
    checks++;
    if (obs_wr.size() == 3 && obs_wr[2].data !== 64'h0015_0103_0003_0002) begin
      failures++;
      $display("FAIL hold_data: got %h expected 0015010300030002", obs_wr[2].data);
    end
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < 10; i++) mem0[8'h80 + i] = 32'h0101_0101;
    @(negedge clk);
    run_count_i = CB'(10); mode_i = 2'd0; sat_i = 1'b0;
    src_base_i = 8'h80; dst_base_i = 8'h90; start_run_i = 1'b1;
    @(posedge clk); #1;
    start_run_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (!(ce_b0_o && ce_b1_o)) begin
      failures++;
      $display("FAIL abort_busy: got ce0=%b ce1=%b expected 1 1", ce_b0_o, ce_b1_o);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({idle_o, read_o, write_o, done_o, ce_b0_o, ce_b1_o, we_b1_o} !== 7'b100_0000) begin
      failures++;
      $display("FAIL abort_flags: got %b expected 1000000",
               {idle_o, read_o, write_o, done_o, ce_b0_o, ce_b1_o, we_b1_o});
    end
    checks++;
    if ({addr_b0_o, addr_b1_o, d_b1_o} !== '0) begin
      failures++;
      $display("FAIL abort_buses: got a0=%h a1=%h d1=%h expected zero", addr_b0_o, addr_b1_o, d_b1_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    test_running_sum();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = 32'h0;
    test_reset();
    test_running_sum();
    test_final_sum();
    test_running_max();
    test_saturation();
    test_zero_rows();
    test_addr_wrap();
    test_start_held();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
